// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } ifetch_state_t;

  localparam logic [31:0] PC_STEP_DEF = 32'd4;
  localparam logic [31:0] FAULT_INSTR = 32'h0000_0000;

endpackage

// File: rtl/ifetch_redir_latch.sv
// Kill flag plus pending redirect target for a fetch that is already in flight.
// Set (latest redirect wins) has priority over clear.
module ifetch_redir_latch (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_set,
  input  logic [31:0] i_set_pc,
  input  logic        i_clr,
  output logic        o_kill,
  output logic [31:0] o_pc
);

  logic        r_kill;
  logic [31:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_kill <= 1'b0;
      r_pc   <= 32'h0;
    end else if (i_set) begin
      r_kill <= 1'b1;
      r_pc   <= i_set_pc;
    end else if (i_clr) begin
      r_kill <= 1'b0;
    end
  end

  assign o_kill = r_kill;
  assign o_pc   = r_pc;

endmodule

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch: PC -> imem request -> decode handshake.
// Optional misaligned-PC fault path enabled by IFETCH_ALIGN_CHK_EN.
//
// state | meaning
// IDLE  | after reset; all outputs 0, stale memory responses ignored
// REQ   | request at PC held until granted
// WAIT  | waiting for read data; killed fetches are dropped here
// OUT   | instruction presented to decode
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] PC_STEP    = PC_STEP_DEF,
  parameter int          ALIGN_BITS = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  output logic        o_pc_en,
  output logic [31:0] o_pc_next,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_fault
);

  ifetch_state_t r_state;
  logic [31:0]   r_instr;
  logic [31:0]   r_instr_pc;

  logic          w_in_req;
  logic          w_in_wait;
  logic          w_in_out;
  logic          w_misaligned;
  logic          w_kill;
  logic          w_kill_now;
  logic [31:0]   w_pend_pc;
  logic          w_set;
  logic          w_clr;

  assign w_in_req  = (r_state == ST_REQ);
  assign w_in_wait = (r_state == ST_WAIT);
  assign w_in_out  = (r_state == ST_OUT);

`ifdef IFETCH_ALIGN_CHK_EN
  logic r_instr_fault;
  assign w_misaligned  = |i_pc[ALIGN_BITS-1:0];
  assign o_instr_fault = r_instr_fault;
`else
  assign w_misaligned  = 1'b0;
  assign o_instr_fault = 1'b0;
`endif

  // A redirect coinciding with the response kills that response directly,
  // so the latch only needs to remember redirects that precede it.
  assign w_kill_now = w_kill | i_redirect;
  assign w_set      = i_redirect & ((w_in_req & ~w_misaligned) | (w_in_wait & ~i_imem_rvalid));
  assign w_clr      = w_in_wait & i_imem_rvalid;

  ifetch_redir_latch u_redir (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_set    (w_set),
    .i_set_pc (i_redirect_pc),
    .i_clr    (w_clr),
    .o_kill   (w_kill),
    .o_pc     (w_pend_pc)
  );

  always_comb begin
    o_pc_en   = 1'b0;
    o_pc_next = 32'h0;
    if (w_in_wait && i_imem_rvalid && w_kill_now) begin
      o_pc_en   = 1'b1;
      o_pc_next = i_redirect ? i_redirect_pc : w_pend_pc;
    end else if (w_in_out && i_redirect) begin
      o_pc_en   = 1'b1;
      o_pc_next = i_redirect_pc;
    end else if (w_in_out && i_instr_ready) begin
      o_pc_en   = 1'b1;
      o_pc_next = i_pc + PC_STEP;
    end else if (w_in_req && w_misaligned && i_redirect) begin
      o_pc_en   = 1'b1;
      o_pc_next = i_redirect_pc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_instr       <= 32'h0;
      r_instr_pc    <= 32'h0;
`ifdef IFETCH_ALIGN_CHK_EN
      r_instr_fault <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_REQ;
        ST_REQ: begin
`ifdef IFETCH_ALIGN_CHK_EN
          if (w_misaligned) begin
            if (!i_redirect) begin
              r_state       <= ST_OUT;
              r_instr       <= FAULT_INSTR;
              r_instr_pc    <= i_pc;
              r_instr_fault <= 1'b1;
            end
          end else
`endif
          if (i_imem_gnt) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_imem_rvalid) begin
            if (w_kill_now) begin
              r_state <= ST_REQ;
            end else begin
              r_state    <= ST_OUT;
              r_instr    <= i_imem_rdata;
              r_instr_pc <= i_pc;
            end
          end
        end
        ST_OUT: begin
          if (i_redirect || i_instr_ready) begin
            r_state       <= ST_REQ;
`ifdef IFETCH_ALIGN_CHK_EN
            r_instr_fault <= 1'b0;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_imem_req    = w_in_req & ~w_misaligned;
  assign o_imem_addr   = w_in_req ? i_pc : 32'h0;
  assign o_instr_valid = w_in_out;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a PC register model and a memory responder
// surround the DUT; expected requests, instructions and PC updates are queued.
module tb_ifetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_instr_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_en;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;

  int n_checks;
  int n_fail;

  logic [31:0] q_addr[$];
  logic [31:0] q_pcn[$];
  exp_instr_t  q_instr[$];

  int          gnt_delay;
  int          rsp_delay;
  int          wait_cnt;
  logic        pend;
  logic [31:0] rsp_addr;

  ifetch_unit dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_pc          (pc),
    .o_pc_en       (pc_en),
    .o_pc_next     (pc_next),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_instr_valid (instr_valid),
    .i_instr_ready (instr_ready),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .o_instr_fault (instr_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register the DUT reads and updates
  always @(posedge clk) begin
    if (!rst_n) pc <= 32'h0;
    else if (pc_en) pc <= pc_next;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_instr(input logic [31:0] i, input logic [31:0] p, input logic f);
    exp_instr_t e;
    e.instr = i;
    e.pc    = p;
    e.fault = f;
    q_instr.push_back(e);
  endtask

  // Memory: grant after gnt_delay REQ cycles, data = addr ^ 0x11111111
  initial begin
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    wait_cnt = 0;
    pend = 1'b0;
    rsp_addr = 32'h0;
    forever begin
      @(negedge clk);
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      if (pend) begin
        if (rsp_delay > 0) rsp_delay--;
        else begin
          imem_rvalid = 1'b1;
          imem_rdata = rsp_addr ^ 32'h1111_1111;
          pend = 1'b0;
        end
      end else if (imem_req === 1'b1) begin
        if (wait_cnt >= gnt_delay) begin
          imem_gnt = 1'b1;
          pend = 1'b1;
          rsp_addr = imem_addr;
          wait_cnt = 0;
          gnt_delay = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (imem_req === 1'b1) begin
          if (q_addr.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_req: addr 0x%08h, none expected", imem_addr);
          end else begin
            chk("imem_addr", imem_addr, q_addr[0]);
            if (imem_gnt) void'(q_addr.pop_front());
          end
        end
        if (instr_valid === 1'b1) begin
          if (q_instr.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_instr: instr 0x%08h pc 0x%08h", instr, instr_pc);
          end else begin
            chk("instr", instr, q_instr[0].instr);
            chk("instr_pc", instr_pc, q_instr[0].pc);
            chk("instr_fault", {31'h0, instr_fault}, {31'h0, q_instr[0].fault});
            if (instr_ready || redirect) void'(q_instr.pop_front());
          end
        end
        if (pc_en === 1'b1) begin
          if (q_pcn.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_pc_en: pc_next 0x%08h", pc_next);
          end else begin
            chk("pc_next", pc_next, q_pcn.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_valid(output int cyc);
    cyc = 0;
    #2;
    while (instr_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    if (instr_valid !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL wait_valid: timeout, instr_valid got 0 expected 1");
    end
  endtask

  task automatic accept();
    @(negedge clk);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    gnt_delay = 0;
    rsp_delay = 0;

    repeat (3) @(negedge clk);
    #2;
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_pc_en", {31'h0, pc_en}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_instr_fault", {31'h0, instr_fault}, 32'h0);

    // Zero-wait fetch at 0
    q_addr.push_back(32'h0);
    push_instr(32'h1111_1111, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(cyc);
    chk("first_latency", cyc, 32'd3);

    // Backpressure on the instruction at 4
    q_pcn.push_back(32'h4);
    q_addr.push_back(32'h4);
    push_instr(32'h1111_1115, 32'h4, 1'b0);
    accept();
    wait_valid(cyc);
    chk("steady_latency", cyc, 32'd2);
    repeat (5) begin
      @(negedge clk);
      #2;
      chk("bp_pc_en", {31'h0, pc_en}, 32'h0);
      chk("bp_instr", instr, 32'h1111_1115);
    end

    // Delayed grant with a redirect in the second REQ cycle
    q_pcn.push_back(32'h8);
    q_addr.push_back(32'h8);
    q_pcn.push_back(32'h200);
    q_addr.push_back(32'h200);
    push_instr(32'h1111_1311, 32'h200, 1'b0);
    gnt_delay = 3;
    accept();
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    wait_valid(cyc);

    // Redirect wins over ready in OUT
    q_pcn.push_back(32'h300);
    q_addr.push_back(32'h300);
    push_instr(32'h1111_1211, 32'h300, 1'b0);
    @(negedge clk);
    instr_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h300;
    @(negedge clk);
    instr_ready = 1'b0;
    redirect = 1'b0;
    wait_valid(cyc);

    // Reset during WAIT; stale response lands while in IDLE
    q_pcn.push_back(32'h304);
    q_addr.push_back(32'h304);
    rsp_delay = 1;
    accept();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q_addr.push_back(32'h0);
    push_instr(32'h1111_1111, 32'h0, 1'b0);
    #2;
    chk("idle_rvalid_seen", {31'h0, imem_rvalid}, 32'h1);
    chk("idle_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("idle_imem_req", {31'h0, imem_req}, 32'h0);
    chk("idle_instr", instr, 32'h0);
    wait_valid(cyc);
    chk("restart_latency", cyc, 32'd3);

    // Redirect to a misaligned PC
    q_pcn.push_back(32'h4);
    q_addr.push_back(32'h4);
    push_instr(32'h1111_1115, 32'h4, 1'b0);
    accept();
    wait_valid(cyc);
    q_pcn.push_back(32'h102);
`ifdef IFETCH_ALIGN_CHK_EN
    push_instr(32'h0, 32'h102, 1'b1);
`else
    q_addr.push_back(32'h102);
    push_instr(32'h1111_1013, 32'h102, 1'b0);
`endif
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    redirect = 1'b0;
    wait_valid(cyc);
    chk("misalign_instr_pc", instr_pc, 32'h102);
`ifdef IFETCH_ALIGN_CHK_EN
    chk("misalign_fault", {31'h0, instr_fault}, 32'h1);
`else
    chk("misalign_fault", {31'h0, instr_fault}, 32'h0);
`endif

    repeat (3) @(negedge clk);
    #2;
    chk("left_addr", q_addr.size(), 32'd0);
    chk("left_pcn", q_pcn.size(), 32'd0);
    chk("left_instr", q_instr.size(), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
